// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared widths, power scaling and FSM encoding for the Goertzel bin detector
package goertzel_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 48;
  localparam int DEF_COEF_FRAC  = 16;
  localparam int COEF_WIDTH     = 18;
  localparam int LEN_WIDTH      = 16;
  localparam int POWER_SHIFT    = 32;
  typedef enum logic [2:0] {IDLE, ACCUM, FIN1, FIN2, FIN3, DONE} state_t;
endpackage

// File: rtl/goertzel_mac.sv
// goertzel_mac: signed coeff*x >>> COEF_FRAC, saturated to the ACC_WIDTH range
module goertzel_mac
  import goertzel_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic signed [COEF_WIDTH-1:0] coeff,
  input  logic signed [ACC_WIDTH-1:0]  x,
  output logic signed [ACC_WIDTH-1:0]  y
);
  localparam int PW = COEF_WIDTH + ACC_WIDTH;
  localparam logic signed [PW-1:0] MAXV = {{(PW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  logic signed [PW-1:0] prod, shifted;
  assign prod    = coeff * x;
  assign shifted = prod >>> COEF_FRAC;
  assign y = shifted > MAXV ? MAXV[ACC_WIDTH-1:0] :
             shifted < MINV ? MINV[ACC_WIDTH-1:0] : shifted[ACC_WIDTH-1:0];
endmodule

// File: rtl/goertzel_bin.sv
// goertzel_bin: single-bin Goertzel power detector over blocks of block_len samples,
// followed by a three-cycle finalisation that squares the state into an unsigned power.
module goertzel_bin
  import goertzel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int COEF_FRAC  = DEF_COEF_FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [COEF_WIDTH-1:0] coeff,
  input  logic        [LEN_WIDTH-1:0]  block_len,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         busy,
  output logic                         done,
  output logic        [63:0]           power
);
  localparam int SW  = ACC_WIDTH + 2;
  localparam int PW  = 2 * ACC_WIDTH;
  localparam int PSW = PW + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  state_t state, state_n;
  logic signed [COEF_WIDTH-1:0] coef_r;
  logic        [LEN_WIDTH-1:0]  len_r, count;
  logic signed [ACC_WIDTH-1:0]  s1, s2, s0, m;
  logic signed [SW-1:0]         sum;
  logic signed [PW-1:0]         p1, p2, p3;
  logic signed [PSW-1:0]        diff, shifted;
  logic        [63:0]           power_n;
  logic                         accept, take;

  assign accept = start && (state == IDLE || state == DONE);
  assign take   = sample_valid && state == ACCUM;

  // the same multiplier serves the recurrence in ACCUM and the cross term in FIN3
  goertzel_mac #(.ACC_WIDTH(ACC_WIDTH), .COEF_FRAC(COEF_FRAC)) u_mac (
    .coeff(coef_r),
    .x    (s1),
    .y    (m)
  );

  assign sum = sample_in + m - s2;
  assign s0  = sum > SMAX ? SMAX[ACC_WIDTH-1:0] : sum < SMIN ? SMIN[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];

  // cross term is formed combinationally so power can be loaded on the FIN3->DONE edge
  assign p3      = m * s2;
  assign diff    = p1 + p2 - p3;
  assign shifted = diff >>> POWER_SHIFT;
  assign power_n = diff[PSW-1] ? '0 : |shifted[PSW-1:64] ? '1 : shifted[63:0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? (block_len == '0 ? FIN1 : ACCUM) : IDLE;
      ACCUM:      state_n = take && count + 16'd1 == len_r ? FIN1 : ACCUM;
      FIN1:       state_n = FIN2;
      FIN2:       state_n = FIN3;
      FIN3:       state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = state inside {ACCUM, FIN1, FIN2, FIN3};
    done = state == DONE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      coef_r <= '0;
      len_r  <= '0;
      count  <= '0;
      s1     <= '0;
      s2     <= '0;
      p1     <= '0;
      p2     <= '0;
      power  <= '0;
    end else begin
      if (accept) begin
        coef_r <= coeff;
        len_r  <= block_len;
        count  <= '0;
        s1     <= '0;
        s2     <= '0;
      end
      if (take) begin
        s1    <= s0;
        s2    <= s1;
        count <= count + 16'd1;
      end
      if (state == FIN1) p1 <= s1 * s1;
      if (state == FIN2) p2 <= s2 * s2;
      if (state == FIN3) power <= power_n;
    end
endmodule

// File: tb/tb_goertzel_bin.sv
// tb_goertzel_bin: directed vectors for goertzel_bin with hand-derived powers and done latency
module tb_goertzel_bin;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [17:0] coeff = '0;
  logic        [15:0] block_len = '0;
  logic               sample_valid = 1'b0;
  logic signed [31:0] sample_in = '0;
  logic               busy, done;
  logic        [63:0] power;
  int                 passed = 0;
  int                 total = 0;

  goertzel_bin dut (
    .clk(clk), .rst(rst), .start(start), .coeff(coeff), .block_len(block_len),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .busy(busy), .done(done), .power(power)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else passed++;
  endtask

  task automatic do_start(input logic signed [17:0] c, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; coeff = c; block_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] x);
    @(negedge clk);
    sample_valid = 1'b1; sample_in = x;
    @(negedge clk);
    sample_valid = 1'b0; sample_in = 32'sh5A5A_5A5A;
  endtask

  // returns on the cycle done is seen; done is expected in the 4th cycle after the last sample edge
  task automatic wait_lat(input string tag);
    int lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp);
    wait_lat(tag);
    check({tag, "_pow"}, power, exp);
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_hold"}, power, exp);
  endtask

  function automatic logic signed [127:0] clip(input logic signed [127:0] v);
    logic signed [127:0] lim;
    lim = (128'sd1 <<< 47) - 128'sd1;
    if (v > lim) return lim;
    if (v < -lim - 128'sd1) return -lim - 128'sd1;
    return v;
  endfunction

  function automatic logic [63:0] ref_power(input int n, input longint c, input longint x);
    logic signed [127:0] a, b, t, m;
    a = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      m = clip((c * a) >>> 16);
      t = clip(x + m - b);
      b = a;
      a = t;
    end
    m = clip((c * a) >>> 16);
    t = (a * a + b * b - m * b) >>> 32;
    if (t < 0) return 64'd0;
    if (t > 128'sd18446744073709551615) return '1;
    return t[63:0];
  endfunction

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_power", power, 64'd0);
    rst = 1'b1;

    do_start(18'sd0, 16'd2);
    check("acc_busy", {63'd0, busy}, 64'd1);
    send(32'sd1048576);
    send(32'sd1048576);
    wait_done("dc2", 64'd512);

    do_start(18'sd65536, 16'd3);
    send(32'sd1048576);
    send(32'sd0);
    send(32'sd0);
    wait_done("unity3", 64'd256);

    do_start(18'sd0, 16'd2);
    send(32'sd1048576);
    repeat (3) @(negedge clk);
    send(32'sd1048576);
    wait_done("gap", 64'd512);

    do_start(18'sd0, 16'd0);
    check("n0_busy", {63'd0, busy}, 64'd1);
    wait_done("n0", 64'd0);

    do_start(18'sd0, 16'd2);
    send(32'sd1048576);
    do_start(18'sd65536, 16'd5);
    send(32'sd1048576);
    wait_done("ign_start", 64'd512);

    do_start(18'sd0, 16'd2);
    send(32'sd1048576);
    send(32'sd1048576);
    wait_lat("b2b_a");
    check("b2b_a_pow", power, 64'd512);
    start = 1'b1; coeff = 18'sd65536; block_len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    send(32'sd1048576);
    send(32'sd0);
    send(32'sd0);
    wait_done("b2b_b", 64'd256);

    do_start(18'sd0, 16'd4);
    send(32'sd1048576);
    send(32'sd1048576);
    rst = 1'b0;
    #1;
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_done", {63'd0, done}, 64'd0);
    check("mid_power", power, 64'd0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_nodone", 64'(ndone), 64'd0);
    rst = 1'b1;
    do_start(18'sd0, 16'd2);
    send(32'sd1048576);
    send(32'sd1048576);
    wait_done("post_rst", 64'd512);

    do_start(18'sd131071, 16'd64);
    for (int i = 0; i < 64; i++) send(32'sd2147483647);
    wait_done("sat64", ref_power(64, 131071, 2147483647));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/goertzel_bin.md
GOERTZEL_BIN -- requirements
Module: goertzel_bin

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the signed width of the filter output sample consumed.
REQ-002 Parameter ACC_WIDTH, default 48, sets the signed width of the Goertzel state registers s1/s2.
REQ-003 Parameter COEF_FRAC, default 16, sets the fractional bits of coeff (Q2.16).
REQ-004 clk  input  1  sample clock, rising edge, one sample slot per cycle.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a new measurement block; accepted only in IDLE or DONE.
REQ-007 coeff  input  18  signed 2*cos(2*pi*k/N) in Q2.16, latched on accepted start.
REQ-008 block_len  input  16  number of samples N per block, latched on accepted start.
REQ-009 sample_valid  input  1  sample_in is valid this cycle.
REQ-010 sample_in  input  DATA_WIDTH  signed FIR filter output sample.
REQ-011 busy  output  1  high in ACCUM and FINAL states.
REQ-012 done  output  1  single-cycle pulse when power is valid.
REQ-013 power  output  64  unsigned bin power, held stable until the next done.

Function
REQ-014 The block SHALL implement the states IDLE, ACCUM, FIN1, FIN2, FIN3, DONE.
REQ-015 IDLE/DONE + start: latch coeff and block_len, clear s1, s2 and the sample counter; go to ACCUM, or to FIN1 when block_len==0.
REQ-016 ACCUM SHALL, per cycle with sample_valid high: s0 = sample_in + ((coeff*s1)>>>COEF_FRAC) - s2; s2<=s1; s1<=s0; count+1.
REQ-017 sample_valid low in ACCUM SHALL leave s1, s2 and count unchanged.
REQ-018 On the cycle count reaches block_len, ACCUM SHALL go to FIN1.
REQ-019 s0 SHALL be computed at full precision, then saturated to the signed ACC_WIDTH range (no wrap).
REQ-020 FIN1 SHALL register p1=s1*s1; FIN2: p2=s2*s2; FIN3: p3=((coeff*s1)>>>COEF_FRAC)*s2.
REQ-021 Leaving FIN3, power SHALL be (p1+p2-p3)>>>32, clamped to 0 if negative and to 2^64-1 if above.
REQ-022 The FIN3->DONE transition SHALL drive power and assert done for exactly one cycle (DONE state); DONE then goes to IDLE unless start is high.
REQ-023 done SHALL assert exactly 4 cycles after the clock edge accepting the last sample.
REQ-024 start in ACCUM or FIN1..FIN3 SHALL be ignored; sample_valid outside ACCUM SHALL be ignored.
REQ-025 start high in DONE SHALL be accepted that cycle (back-to-back blocks, no IDLE cycle).

Reset
REQ-026 rst low SHALL asynchronously force state IDLE, busy 0, done 0, power 0, s1/s2/count/p1/p2/p3 0.
REQ-027 Reset mid-block SHALL discard the partial block; no done is produced for it.
REQ-028 After rst release the first accepted start SHALL behave identically to the first start after power-up.

Structure
REQ-029 State encoding, DATA_WIDTH/ACC_WIDTH/COEF_FRAC defaults and the power shift constant (32) SHALL live in a shared package goertzel_pkg.
REQ-030 The signed saturating multiply-shift (coeff*x>>>COEF_FRAC, saturated to ACC_WIDTH) SHALL be one sub-module, goertzel_mac, reused in ACCUM and FIN3.

Verification
REQ-031 coeff=0, N=2, samples 2^20,2^20 -> done 4 cycles after 2nd sample, power=512.
REQ-032 coeff=65536 (1.0), N=3, samples 2^20,0,0 -> s1=0, s2=2^20, power=256.
REQ-033 N=2 with sample_valid low for 3 cycles between samples, coeff=0, samples 2^20,2^20 -> power=512 unchanged.
REQ-034 N=0 start -> busy for 3 cycles, done pulse, power=0; start during ACCUM ignored (N unchanged).
REQ-035 rst low midway through N=4 block -> all outputs 0 immediately, no done; a new N=2 block afterwards -> power=512 (coeff=0, 2^20 inputs).
REQ-036 sample_in=2^31-1 for N=64, coeff=131071 -> s1/s2 saturate at ±(2^47-1) without sign flip, done still at count 64+4.
